// File: rtl/rigel_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rigel_ram_pkg
// Description : Shared write-mode encoding and address-width helper for the
//               rigel RAM family.
// Revision    : 1.0 - initial release
// ============================================================================
package rigel_ram_pkg;

    typedef enum logic [1:0] {
        c_wm_write_first = 2'd0,
        c_wm_read_first  = 2'd1,
        c_wm_no_change   = 2'd2
    } wmode_t;

    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction

    // Unknown strings fall back to write_first, the most common primitive default.
    function automatic wmode_t wmode_decode(input string mode);
        if (mode == "read_first") return c_wm_read_first;
        if (mode == "no_change")  return c_wm_no_change;
        return c_wm_write_first;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_2port_param_if.sv
`default_nettype none
// ============================================================================
// Module      : bram_2port_param_if
// Description : Two-port RAM access bundle (per-port control, data, status).
// Revision    : 1.0 - initial release
// ============================================================================
interface bram_2port_param_if #(
    parameter int BITS  = 2,
    parameter int DEPTH = 8192
);
    import rigel_ram_pkg::*;

    localparam int c_addr_bits = addr_bits(DEPTH);

    logic                   ena;
    logic                   wea;
    logic                   ssra;
    logic [c_addr_bits-1:0] addra;
    logic [BITS-1:0]        dia;
    logic [BITS-1:0]        doa;
    logic                   doa_valid;

    logic                   enb;
    logic                   web;
    logic                   ssrb;
    logic [c_addr_bits-1:0] addrb;
    logic [BITS-1:0]        dib;
    logic [BITS-1:0]        dob;
    logic                   dob_valid;

    logic                   collision;

    modport master (
        output ena, wea, ssra, addra, dia,
        output enb, web, ssrb, addrb, dib,
        input  doa, doa_valid, dob, dob_valid, collision
    );

    modport slave (
        input  ena, wea, ssra, addra, dia,
        input  enb, web, ssrb, addrb, dib,
        output doa, doa_valid, dob, dob_valid, collision
    );

endinterface
`default_nettype wire

// File: rtl/bram_port_out.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_out
// Description : Per-port output path: write-mode mux, SSR, optional output
//               register and valid tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_out
    import rigel_ram_pkg::*;
#(
    parameter int              BITS    = 2,
    parameter wmode_t          MODE    = c_wm_write_first,
    parameter int              OUT_REG = 0,
    parameter logic [BITS-1:0] SRVAL   = '0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_en,
    input  wire logic            i_we,
    input  wire logic            i_ssr,
    input  wire logic [BITS-1:0] i_di,
    input  wire logic [BITS-1:0] i_rd,
    output logic      [BITS-1:0] o_do,
    output logic                 o_do_valid
);

    // First stage is the output itself when there is no extra register.
    localparam logic [BITS-1:0] c_s1_rst = (OUT_REG != 0) ? '0 : SRVAL;

    logic [BITS-1:0] r_s1;
    logic            r_s1_valid;
    logic [BITS-1:0] w_s1_d;
    logic            w_s1_valid;

    always_comb begin
        w_s1_d     = i_rd;
        w_s1_valid = 1'b1;
        if (i_we) begin
            case (MODE)
                c_wm_read_first: w_s1_d = i_rd;
                c_wm_no_change: begin
                    w_s1_d     = r_s1;
                    w_s1_valid = 1'b0;
                end
                default:         w_s1_d = i_di;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= c_s1_rst;
            r_s1_valid <= 1'b0;
        end else if (i_en) begin
            if (i_ssr && (OUT_REG == 0)) begin
                r_s1       <= SRVAL;
                r_s1_valid <= 1'b1;
            end else begin
                r_s1       <= w_s1_d;
                r_s1_valid <= w_s1_valid;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [BITS-1:0] r_do;
            logic            r_do_valid;

            // SSR acts on this stage; both stages advance only with the enable.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_do       <= SRVAL;
                    r_do_valid <= 1'b0;
                end else if (i_en) begin
                    if (i_ssr) begin
                        r_do       <= SRVAL;
                        r_do_valid <= 1'b1;
                    end else begin
                        r_do       <= r_s1;
                        r_do_valid <= r_s1_valid;
                    end
                end
            end

            assign o_do       = r_do;
            assign o_do_valid = r_do_valid;
        end else begin : g_no_out_reg
            assign o_do       = r_s1;
            assign o_do_valid = r_s1_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bram_2port_param.sv
`default_nettype none
// ============================================================================
// Module      : bram_2port_param
// Description : Parameterised true dual-port block RAM, single clock.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_2port_param
    import rigel_ram_pkg::*;
#(
    parameter int              BITS         = 2,
    parameter int              DEPTH        = 8192,
    parameter string           WRITE_MODE_A = "write_first",
    parameter string           WRITE_MODE_B = "write_first",
    parameter int              OUT_REG      = 0,
    parameter logic [BITS-1:0] SRVAL        = '0,
    parameter logic [BITS-1:0] INIT_VALUE   = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    bram_2port_param_if.slave  bus
);

    localparam wmode_t c_mode_a = wmode_decode(WRITE_MODE_A);
    localparam wmode_t c_mode_b = wmode_decode(WRITE_MODE_B);

    logic [BITS-1:0] r_mem [DEPTH] = '{default: INIT_VALUE};
    logic            r_collision;

    logic w_wr_a;
    logic w_wr_b;
    logic [BITS-1:0] w_doa;
    logic [BITS-1:0] w_dob;
    logic            w_doa_valid;
    logic            w_dob_valid;

    assign w_wr_a = bus.ena & bus.wea & ~reset;
    assign w_wr_b = bus.enb & bus.web & ~reset;

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (w_wr_a) r_mem[bus.addra] <= bus.dia;
        if (w_wr_b) r_mem[bus.addrb] <= bus.dib;
    end

    always_ff @(posedge clk) begin
        if (reset) r_collision <= 1'b0;
        else       r_collision <= w_wr_a & w_wr_b & (bus.addra == bus.addrb);
    end

    bram_port_out #(
        .BITS    (BITS),
        .MODE    (c_mode_a),
        .OUT_REG (OUT_REG),
        .SRVAL   (SRVAL)
    ) u_port_a (
        .clk        (clk),
        .reset      (reset),
        .i_en       (bus.ena),
        .i_we       (bus.wea),
        .i_ssr      (bus.ssra),
        .i_di       (bus.dia),
        .i_rd       (r_mem[bus.addra]),
        .o_do       (w_doa),
        .o_do_valid (w_doa_valid)
    );

    bram_port_out #(
        .BITS    (BITS),
        .MODE    (c_mode_b),
        .OUT_REG (OUT_REG),
        .SRVAL   (SRVAL)
    ) u_port_b (
        .clk        (clk),
        .reset      (reset),
        .i_en       (bus.enb),
        .i_we       (bus.web),
        .i_ssr      (bus.ssrb),
        .i_di       (bus.dib),
        .i_rd       (r_mem[bus.addrb]),
        .o_do       (w_dob),
        .o_do_valid (w_dob_valid)
    );

    assign bus.doa       = w_doa;
    assign bus.doa_valid = w_doa_valid;
    assign bus.dob       = w_dob;
    assign bus.dob_valid = w_dob_valid;
    assign bus.collision = r_collision;

endmodule
`default_nettype wire
